// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A shadow copy of the packed nibbles is scanned one digit per refresh slot.
// Segment and digit-enable outputs are active-low and fully registered.
// Each slot opens with a short anti-ghosting window where all anodes are off.
module seven_segment_mux_driver #(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_load,
    input  logic                    i_enable,
    output logic [7:0]              o_sevenSegmentLed,
    output logic [NUM_DIGITS-1:0]   o_digitEnable,
    output logic                    o_frameDone
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        index;

    logic                    slot_end;
    logic                    last_digit;
    logic                    in_blank;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_zero_from;
    logic                    lz_blank;
    logic [7:0]              glyph_code;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   digit_onehot;

    // Active-low glyph table; bit 0 (dp) is always 1 here and merged later.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'b0000_0011;
            4'h1:    code = 8'b1001_1111;
            4'h2:    code = 8'b0010_0101;
            4'h3:    code = 8'b0000_1101;
            4'h4:    code = 8'b1001_1001;
            4'h5:    code = 8'b0100_1001;
            4'h6:    code = 8'b0100_0001;
            4'h7:    code = 8'b0001_1111;
            4'h8:    code = 8'b0000_0001;
            4'h9:    code = 8'b0001_1001;
            4'hA:    code = (HEX_MODE != 0) ? 8'b0001_0001 : 8'hFF;
            4'hB:    code = (HEX_MODE != 0) ? 8'b1100_0001 : 8'hFF;
            4'hC:    code = (HEX_MODE != 0) ? 8'b0110_0011 : 8'hFF;
            4'hD:    code = (HEX_MODE != 0) ? 8'b1000_0101 : 8'hFF;
            4'hE:    code = (HEX_MODE != 0) ? 8'b0110_0001 : 8'hFF;
            default: code = (HEX_MODE != 0) ? 8'b0111_0001 : 8'hFF;
        endcase
        return code;
    endfunction

    assign slot_end   = (prescaler == PRE_W'(REFRESH_DIV - 1));
    assign last_digit = (index == IDX_W'(NUM_DIGITS - 1));

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (prescaler < PRE_W'(BLANK_CYCLES));
        end
    endgenerate

    // Capture new display contents; loads are honoured even while disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
        end else if (i_load) begin
            shadow_digits <= i_digits;
            shadow_dp     <= i_dp;
        end
    end

    // Slot prescaler and digit index; both freeze while the scan is disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prescaler <= '0;
            index     <= '0;
        end else if (i_enable) begin
            if (slot_end) begin
                prescaler <= '0;
                index     <= last_digit ? '0 : index + IDX_W'(1);
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    // zero_from[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic        acc;
        int unsigned k;
        zero_from = '0;
        acc       = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            k            = NUM_DIGITS - 1 - j;
            acc          = acc & (shadow_digits[4*k +: 4] == 4'h0);
            zero_from[k] = acc;
        end
    end

    // Select the shadow nibble, dp and leading-zero flag for the current index.
    always_comb begin
        cur_nib       = '0;
        cur_dp        = 1'b0;
        cur_zero_from = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k)) begin
                cur_nib       = shadow_digits[4*k +: 4];
                cur_dp        = shadow_dp[k];
                cur_zero_from = zero_from[k];
            end
        end
    end

    // Build the next segment byte; dp survives leading-zero blanking.
    always_comb begin
        lz_blank     = (LZ_BLANK != 0) && (index != '0) && cur_zero_from;
        glyph_code   = glyph(cur_nib);
        seg_next     = {(lz_blank ? 7'h7F : glyph_code[7:1]), ~cur_dp};
        digit_onehot = NUM_DIGITS'(1) << index;
    end

    // Registered pin drivers; everything goes dark while the scan is disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sevenSegmentLed <= 8'hFF;
            o_digitEnable     <= '1;
            o_frameDone       <= 1'b0;
        end else if (i_enable) begin
            o_sevenSegmentLed <= seg_next;
            o_digitEnable     <= in_blank ? '1 : ~digit_onehot;
            o_frameDone       <= slot_end && last_digit;
        end else begin
            o_sevenSegmentLed <= 8'hFF;
            o_digitEnable     <= '1;
            o_frameDone       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Self-checking bench for seven_segment_mux_driver: table-driven decode
// vectors plus directed sequences for reset, freeze and wrap-edge loads.
module tb_seven_segment_mux_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        enable;
    logic [11:0] digits;
    logic [2:0]  dp;

    logic [7:0]  seg_dec, seg_hex, seg_one;
    logic [2:0]  en_dec, en_hex;
    logic [0:0]  en_one;
    logic        fd_dec, fd_hex, fd_one;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_segment_mux_driver #(
        .NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0), .LZ_BLANK(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp(dp),
        .i_load(load), .i_enable(enable),
        .o_sevenSegmentLed(seg_dec), .o_digitEnable(en_dec), .o_frameDone(fd_dec)
    );

    seven_segment_mux_driver #(
        .NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1), .LZ_BLANK(1)
    ) dut_hex (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp(dp),
        .i_load(load), .i_enable(enable),
        .o_sevenSegmentLed(seg_hex), .o_digitEnable(en_hex), .o_frameDone(fd_hex)
    );

    seven_segment_mux_driver #(
        .NUM_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0), .HEX_MODE(0), .LZ_BLANK(1)
    ) dut_one (
        .i_clk(clk), .i_rst(rst), .i_digits(digits[3:0]), .i_dp(dp[0:0]),
        .i_load(load), .i_enable(enable),
        .o_sevenSegmentLed(seg_one), .o_digitEnable(en_one), .o_frameDone(fd_one)
    );

    typedef struct {
        logic [11:0]     digits;
        logic [2:0]      dp;
        logic [2:0][7:0] exp_dec;
        logic [2:0][7:0] exp_hex;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen [3];
        int fd_n;
        int fd1_n;
        logic found;
        logic [2:0] prev;

        // {digits, dp, expected {d2,d1,d0} HEX_MODE=0, expected {d2,d1,d0} HEX_MODE=1}
        vecs[0] = '{12'h123, 3'b010, {8'h9F, 8'h24, 8'h0D}, {8'h9F, 8'h24, 8'h0D}};
        vecs[1] = '{12'h005, 3'b000, {8'hFF, 8'hFF, 8'h49}, {8'hFF, 8'hFF, 8'h49}};
        vecs[2] = '{12'h000, 3'b000, {8'hFF, 8'hFF, 8'h03}, {8'hFF, 8'hFF, 8'h03}};
        vecs[3] = '{12'hAF0, 3'b000, {8'hFF, 8'hFF, 8'h03}, {8'h11, 8'h71, 8'h03}};
        vecs[4] = '{12'h100, 3'b000, {8'h9F, 8'h03, 8'h03}, {8'h9F, 8'h03, 8'h03}};
        vecs[5] = '{12'h050, 3'b111, {8'hFE, 8'h48, 8'h02}, {8'hFE, 8'h48, 8'h02}};
        vecs[6] = '{12'h9B8, 3'b001, {8'h19, 8'hFF, 8'h00}, {8'h19, 8'hC1, 8'h00}};
        vecs[7] = '{12'h0C0, 3'b100, {8'hFE, 8'hFF, 8'h03}, {8'hFE, 8'h63, 8'h03}};

        rst = 1'b1; enable = 1'b0; load = 1'b0; digits = '0; dp = '0;
        repeat (2) tick();
        check("rst_seg", 32'(seg_dec), 32'hFF);
        check("rst_en", 32'(en_dec), 32'h7);
        check("rst_fd", 32'(fd_dec), 32'h0);
        check("rst_en_one", 32'(en_one), 32'h1);

        // First slot after release: blank cycle, then digit 0 showing '0'.
        rst = 1'b0; enable = 1'b1;
        tick();
        check("rel1_en", 32'(en_dec), 32'h7);
        check("rel1_seg", 32'(seg_dec), 32'h03);
        check("rel1_en_one", 32'(en_one), 32'h0);
        tick();
        check("rel2_en", 32'(en_dec), 32'h6);
        check("rel2_seg", 32'(seg_dec), 32'h03);

        // Table-driven decode: load, settle, then watch one full 12-cycle frame.
        for (int v = 0; v < 8; v++) begin
            digits = vecs[v].digits; dp = vecs[v].dp; load = 1'b1;
            tick();
            load = 1'b0;
            tick(); tick();
            for (int k = 0; k < 3; k++) seen[k] = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                check("onehot", 32'($countones(~en_dec) <= 1), 32'h1);
                check($sformatf("v%0d_one", v), 32'(seg_one), 32'(vecs[v].exp_dec[0]));
                for (int k = 0; k < 3; k++) begin
                    if (en_dec[k] == 1'b0) begin
                        seen[k]++;
                        check($sformatf("v%0d_d%0d_dec", v, k), 32'(seg_dec), 32'(vecs[v].exp_dec[k]));
                        check($sformatf("v%0d_d%0d_hex", v, k), 32'(seg_hex), 32'(vecs[v].exp_hex[k]));
                    end
                end
            end
            for (int k = 0; k < 3; k++)
                check($sformatf("v%0d_d%0d_lit_cycles", v, k), 32'(seen[k]), 32'd3);
        end

        // Frame pulse cadence: 12 cycles for 3 digits, 3 cycles for one digit.
        fd_n = 0; fd1_n = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (fd_dec) begin
                fd_n++;
                check("fd_on_last_digit", 32'(en_dec), 32'h3);
            end
            if (fd_one) fd1_n++;
            check("one_en", 32'(en_one), 32'h0);
        end
        check("frame_count", 32'(fd_n), 32'd2);
        check("frame_count_one", 32'(fd1_n), 32'd8);

        // Freeze mid-slot on digit 1, then resume with the remaining cycles.
        digits = 12'h123; dp = 3'b010; load = 1'b1;
        tick();
        load = 1'b0;
        found = 1'b0; prev = 3'b000;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (en_dec == 3'b101 && prev == 3'b111) found = 1'b1;
            prev = en_dec;
        end
        check("sync_digit1", 32'(found), 32'h1);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("dark_seg", 32'(seg_dec), 32'hFF);
            check("dark_en", 32'(en_dec), 32'h7);
            check("dark_fd", 32'(fd_dec | fd_one), 32'h0);
        end
        enable = 1'b1;
        tick();
        check("resume1_en", 32'(en_dec), 32'h5);
        check("resume1_seg", 32'(seg_dec), 32'h24);
        tick();
        check("resume2_en", 32'(en_dec), 32'h5);
        check("resume2_fd", 32'(fd_dec), 32'h0);
        tick();
        check("resume3_en", 32'(en_dec), 32'h7);
        check("resume3_seg", 32'(seg_dec), 32'h9F);
        tick();
        check("resume4_en", 32'(en_dec), 32'h3);

        // Load landing exactly on the digit 0 -> digit 1 wrap edge.
        found = 1'b0; prev = 3'b000;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (en_dec == 3'b110 && prev == 3'b111) found = 1'b1;
            prev = en_dec;
        end
        check("sync_digit0", 32'(found), 32'h1);
        tick();
        digits = 12'h999; dp = 3'b000; load = 1'b1;
        tick();
        load = 1'b0;
        check("wrap_old_en", 32'(en_dec), 32'h6);
        check("wrap_old_seg", 32'(seg_dec), 32'h0D);
        tick();
        check("wrap_blank_en", 32'(en_dec), 32'h7);
        check("wrap_blank_seg", 32'(seg_dec), 32'h19);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("wrap_new_en", 32'(en_dec), 32'h5);
            check("wrap_new_seg", 32'(seg_dec), 32'h19);
        end

        // Asynchronous reset between clock edges, then restart at digit 0.
        #2;
        rst = 1'b1;
        #1;
        check("async_seg", 32'(seg_dec), 32'hFF);
        check("async_en", 32'(en_dec), 32'h7);
        check("async_fd", 32'(fd_dec), 32'h0);
        check("async_seg_one", 32'(seg_one), 32'hFF);
        check("async_en_one", 32'(en_one), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        check("rr1_en", 32'(en_dec), 32'h7);
        check("rr1_seg", 32'(seg_dec), 32'h03);
        check("rr1_seg_one", 32'(seg_one), 32'h03);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rr_digit0_en", 32'(en_dec), 32'h6);
            check("rr_digit0_seg", 32'(seg_dec), 32'h03);
        end
        tick();
        check("rr_digit1_en", 32'(en_dec), 32'h7);
        check("rr_digit1_seg", 32'(seg_dec), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
